// File: rtl/noc_ingress_buffer_if.sv
// noc_ingress_buffer_if: processor capture inputs and crossbar handshake of the ingress buffer
interface noc_ingress_buffer_if #(
  parameter int ADDR_W = 4,
  parameter int FLIT_W = 9
);
  logic              master_response;
  logic [1:0]        which_processor;
  logic [FLIT_W-1:0] data_from_processor;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_data;
  logic [1:0]        out_dest;
  logic [ADDR_W:0]   fifo_level;
  logic              busy;
  logic              overflow;
  logic [7:0]        pkt_count;
  modport master (
    output master_response, which_processor, data_from_processor, out_ready,
    input  out_valid, out_data, out_dest, fifo_level, busy, overflow, pkt_count
  );
  modport slave (
    input  master_response, which_processor, data_from_processor, out_ready,
    output out_valid, out_data, out_dest, fifo_level, busy, overflow, pkt_count
  );
endinterface

// File: rtl/noc_ingress_buffer.sv
// noc_ingress_buffer: grant-triggered flit capture into a show-ahead FIFO tagged with destination; NOC_INGRESS_STATS_EN enables pkt_count
module noc_ingress_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int FLIT_W = 9
) (
  input logic              clock,
  input logic              reset,
  noc_ingress_buffer_if.slave bus
);
  typedef enum logic {IDLE, CAPTURE} state_t;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t             state_q;
  logic [1:0]         dest_q;
  logic [ADDR_W-1:0]  wr_q, rd_q;
  logic [ADDR_W:0]    level_q, level_d;
  logic               overflow_q;
  logic [FLIT_W+1:0]  mem_q [DEPTH];
  logic [FLIT_W+1:0]  head;
  logic               push, pop, wr_en;
  assign push  = state_q == CAPTURE;
  assign pop   = bus.out_ready && level_q != '0;
  assign wr_en = push && (level_q != FULL || pop);
  assign head  = mem_q[rd_q];
  // occupancy follows accepted pushes and pops independently of the pointers
  always_comb level_d = level_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
  // capture FSM, pointers, occupancy and sticky drop flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.master_response) begin
        dest_q  <= bus.which_processor;
        state_q <= CAPTURE;
      end else if (state_q == CAPTURE && bus.data_from_processor[FLIT_W-1]) begin
        state_q <= IDLE;
      end
      wr_q    <= wr_q + ADDR_W'(wr_en);
      rd_q    <= rd_q + ADDR_W'(pop);
      level_q <= level_d;
      if (push && !wr_en) overflow_q <= 1'b1;
    end
  end
  // flit storage carries the destination alongside the flit
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q] <= {dest_q, bus.data_from_processor};
  end
  assign bus.out_valid  = level_q != '0;
  assign bus.out_data   = bus.out_valid ? head[FLIT_W-1:0] : '0;
  assign bus.out_dest   = bus.out_valid ? head[FLIT_W+1:FLIT_W] : '0;
  assign bus.fifo_level = level_q;
  assign bus.busy       = state_q == CAPTURE;
  assign bus.overflow   = overflow_q;
`ifdef NOC_INGRESS_STATS_EN
  logic [7:0] pkt_q;
  // counts packets whose tlast flit leaves the buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pkt_q <= '0;
    else if (pop && head[FLIT_W-1]) pkt_q <= pkt_q + 8'd1;
  end
  assign bus.pkt_count = pkt_q;
`else
  assign bus.pkt_count = '0;
`endif
endmodule

// File: tb/tb_noc_ingress_buffer.sv
// tb_noc_ingress_buffer: directed vector table plus multi-cycle corner sequences
module tb_noc_ingress_buffer;
`ifdef NOC_INGRESS_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  typedef struct {
    logic       mr;
    logic [1:0] wp;
    logic [8:0] d;
    logic       r;
    logic       v;
    logic [8:0] od;
    logic [1:0] odst;
    logic [4:0] lvl;
    logic       bsy;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t tbl [5];
  noc_ingress_buffer_if #(.ADDR_W(4), .FLIT_W(9)) bus ();
  noc_ingress_buffer #(.DEPTH(16), .ADDR_W(4), .FLIT_W(9)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask
  task automatic step(input logic mr, input logic [1:0] wp, input logic [8:0] d, input logic r);
    bus.master_response     = mr;
    bus.which_processor     = wp;
    bus.data_from_processor = d;
    bus.out_ready           = r;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0);
    reset = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1, 2, 9'h000, 1, 0, 9'h000, 0, 0, 1};
    tbl[1] = '{0, 0, 9'h001, 1, 1, 9'h001, 2, 1, 1};
    tbl[2] = '{0, 0, 9'h002, 1, 1, 9'h002, 2, 1, 1};
    tbl[3] = '{0, 0, 9'h103, 1, 1, 9'h103, 2, 1, 0};
    tbl[4] = '{0, 0, 9'h000, 1, 0, 9'h000, 0, 0, 0};
    bus.master_response = 0;
    bus.which_processor = 0;
    bus.data_from_processor = 0;
    bus.out_ready = 0;
    step(0, 0, 0, 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_pkt", 32'(bus.pkt_count), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].mr, tbl[i].wp, tbl[i].d, tbl[i].r);
      chk($sformatf("t1_valid%0d", i), 32'(bus.out_valid), 32'(tbl[i].v));
      chk($sformatf("t1_data%0d", i), 32'(bus.out_data), 32'(tbl[i].od));
      chk($sformatf("t1_dest%0d", i), 32'(bus.out_dest), 32'(tbl[i].odst));
      chk($sformatf("t1_level%0d", i), 32'(bus.fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("t1_busy%0d", i), 32'(bus.busy), 32'(tbl[i].bsy));
    end
    chk("t1_pkt", 32'(bus.pkt_count), 32'(STATS));
    step(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(i == 0, 1, 0, 0);
      if (i == 0) step(0, 0, 9'h000, 0);
    end
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, i == 19 ? 9'h113 : 9'(i), 0);
      if (i == 15) begin
        chk("t2_level16", 32'(bus.fifo_level), 16);
        chk("t2_ovf_pre", 32'(bus.overflow), 0);
      end
    end
    chk("t2_level", 32'(bus.fifo_level), 16);
    chk("t2_ovf", 32'(bus.overflow), 1);
    chk("t2_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_drain%0d", i), 32'(bus.out_data), 32'(i));
      chk($sformatf("t2_dest%0d", i), 32'(bus.out_dest), 1);
      step(0, 0, 0, 1);
    end
    chk("t2_empty", 32'(bus.fifo_level), 0);
    chk("t2_pkt", 32'(bus.pkt_count), 0);
    step(0, 0, 0, 1);
    chk("t2_empty_ready", 32'(bus.fifo_level), 0);
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 9'h020 + 9'(i), 0);
    chk("t3_full", 32'(bus.fifo_level), 16);
    step(0, 0, 9'h130, 1);
    chk("t3_level", 32'(bus.fifo_level), 16);
    chk("t3_ovf", 32'(bus.overflow), 0);
    chk("t3_head", 32'(bus.out_data), 9'h021);
    chk("t3_busy", 32'(bus.busy), 0);
    for (int i = 1; i < 16; i++) step(0, 0, 0, 1);
    chk("t3_tail", 32'(bus.out_data), 9'h130);
    step(0, 0, 0, 1);
    chk("t3_pkt", 32'(bus.pkt_count), 32'(STATS));
    chk("t3_empty", 32'(bus.out_valid), 0);
    do_reset();
    step(1, 1, 0, 1);
    chk("t4_busy", 32'(bus.busy), 1);
    step(1, 3, 9'h011, 1);
    chk("t4_d0", 32'({bus.out_dest, bus.out_data}), 32'({2'd1, 9'h011}));
    step(1, 3, 9'h012, 1);
    chk("t4_d1", 32'({bus.out_dest, bus.out_data}), 32'({2'd1, 9'h012}));
    step(1, 3, 9'h113, 1);
    chk("t4_d2", 32'({bus.out_dest, bus.out_data}), 32'({2'd1, 9'h113}));
    chk("t4_idle", 32'(bus.busy), 0);
    step(1, 3, 0, 1);
    chk("t4_regrant", 32'({bus.busy, bus.fifo_level}), 32'({1'b1, 5'd0}));
    step(0, 0, 9'h144, 1);
    chk("t4_d3", 32'({bus.out_dest, bus.out_data}), 32'({2'd3, 9'h144}));
    do_reset();
    step(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 9'h050 + 9'(i), 0);
    chk("t5_level5", 32'(bus.fifo_level), 5);
    reset = 1'b1;
    #1;
    chk("t5_async", 32'({bus.out_valid, bus.out_data, bus.out_dest, bus.fifo_level, bus.busy, bus.overflow}), 0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    step(1, 2, 0, 1);
    step(0, 0, 9'h055, 1);
    chk("t5_p0", 32'({bus.out_dest, bus.out_data, bus.fifo_level}), 32'({2'd2, 9'h055, 5'd1}));
    step(0, 0, 9'h156, 1);
    chk("t5_p1", 32'({bus.out_dest, bus.out_data, bus.busy}), 32'({2'd2, 9'h156, 1'b0}));
`ifdef NOC_INGRESS_STATS_EN
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 1);
      if (i == 128) chk("t6_mid", 32'(bus.pkt_count), 128);
      step(0, 0, 9'h100 | 9'(i), 1);
    end
    step(0, 0, 0, 1);
    chk("t6_wrap", 32'(bus.pkt_count), 0);
    chk("t6_empty", 32'(bus.fifo_level), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_ingress_buffer.md
Name: noc_ingress_buffer

Overview:
- Router-side ingress stage directly downstream of each processing unit.
- Captures the processor's 9-bit flit stream {tlast, payload[7:0]} once the master grants the transfer.
- Tags each flit with the destination latched at grant and buffers flits in a show-ahead FIFO.
- Presents flits to the router crossbar over a valid/ready handshake.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- FLIT_W, 9, flit width; bit FLIT_W-1 is tlast.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- master_response  input  1  grant from master; 1 = transfer accepted.
- which_processor  input  2  destination id; sampled only on a grant.
- data_from_processor  input  FLIT_W  flit stream from the processing unit.
- out_valid  output  1  head flit available.
- out_ready  input  1  crossbar accepts the head flit.
- out_data  output  FLIT_W  head flit.
- out_dest  output  2  destination of the head flit.
- fifo_level  output  ADDR_W+1  occupancy, 0..DEPTH.
- busy  output  1  state is CAPTURE.
- overflow  output  1  sticky: at least one flit was dropped.
- pkt_count  output  8  count of completed packets popped (see Optional Feature).

Behaviour:
- Reset: state IDLE; read and write pointers 0; fifo_level 0; out_valid 0; out_data 0; out_dest 0; busy 0; overflow 0; pkt_count 0.
- Reset mid-operation discards the FIFO contents and any partial packet.
- FSM, two states:
  - IDLE: if master_response=1 at a rising edge, latch which_processor into dest_reg and go to CAPTURE. Otherwise stay in IDLE. No pushes occur in IDLE.
  - CAPTURE: every rising edge pushes {dest_reg, data_from_processor} as one flit. If the pushed flit has tlast=1, return to IDLE on that same edge. master_response is ignored in CAPTURE.
- A packet is the flits from the first capture edge after the grant up to and including the tlast flit. A 1-flit packet is legal.
- Timing: grant sampled at edge E; first flit sampled at edge E+1.
- Write latency: a flit pushed at edge N gives out_valid=1 after edge N when the FIFO was empty beforehand. No combinational input-to-output path exists.
- Show-ahead output: out_data and out_dest reflect the head entry. When empty, out_valid=0 and out_data/out_dest read 0.
- Pop occurs when out_valid and out_ready are both 1 at an edge.
- Full boundary:
  - A push with fifo_level=DEPTH and no pop in the same cycle drops the flit and sets overflow; overflow clears only on reset.
  - With a pop in the same cycle, the push is accepted and the level is unchanged.
- A dropped tlast flit still returns the FSM to IDLE.
- Empty boundary: out_ready with an empty FIFO is ignored and the level stays 0.
- Simultaneous push and pop at any level: the level is unchanged and both pointers advance.
- Pointers are ADDR_W bits and wrap modulo DEPTH. fifo_level is tracked by a separate counter.
- busy = (state == CAPTURE).

Optional Feature:
- Macro: NOC_INGRESS_STATS_EN.
- Defined: pkt_count increments on each pop of a flit with tlast=1 and wraps 255 to 0. Dropped flits are never counted.
- Undefined: pkt_count is tied to 0 and the counter logic is not synthesised. All other behaviour is identical.

Test Plan:
1. Reset, grant with which_processor=2, then flits 0x001, 0x002, 0x103 with out_ready=1 -> out_data 0x001, 0x002, 0x103 each with out_dest=2. FSM returns to IDLE after 0x103; busy falls; pkt_count=1 when the stats macro is defined.
2. out_ready=0, grant, stream 20 flits with the last having tlast (DEPTH=16) -> fifo_level saturates at 16, overflow=1, 4 flits dropped, FSM in IDLE. Draining returns the first 16 flits in order.
3. FIFO full, push and pop in the same cycle -> level stays 16, overflow stays 0, incoming flit appears at the tail.
4. Grant pulse held during CAPTURE with which_processor changing from 1 to 3 -> all packet flits carry out_dest=1. A second grant after tlast latches 3.
5. Assert reset mid-packet after 5 flits are captured -> outputs return immediately to reset values. A subsequent grant and packet work normally.
6. With the stats macro defined, 256 single-flit packets (0x1xx) drained -> pkt_count wraps back to 0.
